// File: rtl/uart_line_arbiter_pkg.sv
// Shared types and constants for the UART line arbiter and its arbiter helper.
package uart_line_arbiter_pkg;

  localparam int          BYTE_W   = 8;
  localparam logic [7:0]  CHAR_NUL = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SKIP = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Index width that stays legal for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_line_arbiter_if.sv
// Requester-side and transmitter-side signals of the line arbiter.
interface uart_line_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_CHARS = 16
);
  import uart_line_arbiter_pkg::*;

  localparam int LW = MAX_CHARS * BYTE_W;

  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ*LW-1:0] line_in;
  logic [NUM_REQ-1:0]    grant;
  logic [NUM_REQ-1:0]    done;
  logic                  busy;
  logic [BYTE_W-1:0]     tx_data;
  logic                  tx_valid;
  logic                  tx_ready;

  // Arbiter side.
  modport slave (
    input  req, line_in, tx_ready,
    output grant, done, busy, tx_data, tx_valid
  );

  // Requester / transmitter side.
  modport master (
    output req, line_in, tx_ready,
    input  grant, done, busy, tx_data, tx_valid
  );

endinterface

// File: rtl/uart_line_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr wins.
module rr_arbiter
  import uart_line_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic [IDX_W-1:0]   winner_idx,
  output logic               any
);

  // Scan from the farthest offset down so the closest requester to ptr wins last.
  always_comb begin
    int k;
    k          = 0;
    winner     = '0;
    winner_idx = '0;
    any        = 1'b0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      k = (int'(ptr) + off) % NUM_REQ;
      if (req[k]) begin
        winner     = '0;
        winner[k]  = 1'b1;
        winner_idx = IDX_W'(k);
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_line_arbiter.sv
// Round-robin sharing of one byte transmitter among NUM_REQ line producers.
//
//  state | meaning
//  IDLE  | waiting for a request; captures winner's line on the grant edge
//  SKIP  | discarding leading NUL padding of the captured line
//  SEND  | offering bytes to the transmitter until NUL or MAX_CHARS
//  DONE  | one-cycle done pulse, pointer advanced past the winner
module uart_line_arbiter
  import uart_line_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MAX_CHARS = 16
) (
  input logic                clk,
  input logic                rst_n,
  uart_line_arbiter_if.slave bus
);

  localparam int LW    = MAX_CHARS * BYTE_W;
  localparam int IDX_W = idx_width(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_CHARS + 1);

  state_e              state_q, state_d;
  logic [LW-1:0]       sr_q, sr_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    win_q, win_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;

  logic [NUM_REQ-1:0]  rr_onehot;
  logic [IDX_W-1:0]    rr_idx;
  logic                rr_any;
  logic [BYTE_W-1:0]   top_byte;
  logic                top_nul;
  logic                rem_zero;
  logic                hshk;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req        (bus.req),
    .ptr        (ptr_q),
    .winner     (rr_onehot),
    .winner_idx (rr_idx),
    .any        (rr_any)
  );

  assign top_byte = sr_q[LW-1 -: BYTE_W];
  assign top_nul  = (top_byte == CHAR_NUL);
  assign rem_zero = (rem_q == '0);

  // Outputs come only from registered state so nothing leaks from req/line_in.
  always_comb begin
    bus.busy     = (state_q != ST_IDLE);
    bus.grant    = (state_q != ST_IDLE) ? grant_q : '0;
    bus.done     = (state_q == ST_DONE) ? grant_q : '0;
    bus.tx_valid = (state_q == ST_SEND) && !top_nul && !rem_zero;
    bus.tx_data  = (state_q == ST_SEND) ? top_byte : '0;
  end

  assign hshk = bus.tx_valid && bus.tx_ready;

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    rem_d   = rem_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    grant_d = grant_q;
    unique case (state_q)
      ST_IDLE: begin
        if (rr_any) begin
          sr_d    = bus.line_in[rr_idx*LW +: LW];
          rem_d   = CNT_W'(MAX_CHARS);
          win_d   = rr_idx;
          grant_d = rr_onehot;
          state_d = ST_SKIP;
        end
      end
      ST_SKIP: begin
        if (top_nul && !rem_zero) begin
          sr_d  = sr_q << BYTE_W;
          rem_d = rem_q - CNT_W'(1);
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (top_nul || rem_zero) begin
          state_d = ST_DONE;
        end else if (hshk) begin
          sr_d  = sr_q << BYTE_W;
          rem_d = rem_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        grant_d = '0;
        if (int'(win_q) == NUM_REQ - 1) ptr_d = '0;
        else                            ptr_d = win_q + IDX_W'(1);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any line in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      rem_q   <= '0;
      ptr_q   <= '0;
      win_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      rem_q   <= rem_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      grant_q <= grant_d;
    end
  end

endmodule

// File: doc/uart_line_arbiter.md
# uart_line_arbiter

Shares one UART byte transmitter among up to NUM_REQ string producers (key handlers, status reporters, SD-card loggers). Each requester presents a packed, NUL-terminated character line; the arbiter grants requesters round-robin, latches the granted line, and streams its bytes into the transmitter over a valid/ready handshake. It sits between the application logic and the byte-level UART TX, replacing ad-hoc single-writer hookups.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- MAX_CHARS, 16, characters per line; line width LW = MAX_CHARS*8
- clk  input  1  system clock
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low
- req  input  NUM_REQ  level request per requester
- line_in  input  NUM_REQ*LW  requester i's line at bits [(i+1)*LW-1 : i*LW]; first character in the most significant non-NUL byte
- grant  output  NUM_REQ  one-hot, high from capture until done
- done  output  NUM_REQ  one-cycle pulse on the granted bit when its line is finished
- busy  output  1  high in any state other than IDLE
- tx_data  output  8  byte to transmitter
- tx_valid  output  1  byte offered
- tx_ready  input  1  transmitter accepts byte when tx_valid & tx_ready at a rising edge

## Operation
- States: IDLE, SKIP, SEND, DONE.
- IDLE: if any req, pick winner by round-robin starting at pointer ptr; at that edge load line_in slice into shift register sr (LW bits), set remaining = MAX_CHARS, set grant, go SKIP. No req: stay.
- SKIP: leading NUL bytes are discarded (string literals are right-aligned, zero-padded on the left). If sr top byte == 0 and remaining != 0: shift sr left 8, remaining--, stay. Else go SEND.
- SEND: tx_data = sr top byte; tx_valid = (top byte != 0) && (remaining != 0). On handshake: shift left 8, remaining--. If top byte == 0 or remaining == 0: go DONE without asserting tx_valid.
- DONE: done[winner] = 1 for this cycle, grant cleared, ptr = winner+1 (mod NUM_REQ), go IDLE.
- Line captured at grant: requester may change line_in once grant is high.
- req still high after done is a new request, arbitrated with ptr already advanced past it.
- All-NUL line: SKIP exhausts remaining, SEND goes directly to DONE; zero bytes sent, done still pulses.
- Line with no terminator: exactly MAX_CHARS bytes sent (minus skipped leading NULs).
- Embedded NUL after first character ends the line; later bytes dropped.

## Timing
- Reset values: grant 0, done 0, busy 0, tx_valid 0, tx_data 0, ptr 0, state IDLE.
- req high before edge E in IDLE -> grant and busy high after E; first tx_valid earliest at E+2 (one cycle SKIP check), plus one cycle per leading NUL.
- tx_valid, once high, stays high with tx_data stable until accepted; never drops without handshake except on reset.
- Back-to-back bytes: with tx_ready held high, one byte per clock.
- done pulse one cycle after final handshake (or termination detection); next grant earliest the cycle after done.
- Reset mid-line: all outputs to reset values immediately; in-flight line abandoned, no done pulse, ptr to 0.
- tx_valid/tx_data driven from registers and state only; no combinational path from req or line_in to any output.

## Structure
- Shared header uart_defs.vh: state encodings, CHAR_NUL = 8'h00, byte width.
- One sub-module rr_arbiter (NUM_REQ param): inputs req, ptr; outputs one-hot winner and its index; purely combinational, reused by future bus arbiters.
- Datapath (sr, remaining, ptr, state) in uart_line_arbiter.

## Test plan
- Single req[0], line "Hi\n" right-aligned in 16 chars, tx_ready=1 -> bytes 0x48,0x69,0x0A on consecutive cycles, done[0] one cycle later, grant[0] low after.
- req = 4'b1111 held, each line "A","B","C","D" -> grant order 0,1,2,3,0; exactly one done per grant.
- tx_ready toggling 1-in-3 cycles -> tx_valid never drops, tx_data stable, same byte sequence.
- line all zeros on req[2] -> no tx_valid, done[2] after MAX_CHARS+ few cycles; 16 non-zero chars, no NUL -> exactly 16 bytes; "A\0B" -> only 0x41.
- Change line_in[1] after grant[1] -> originally captured bytes sent.
- rst_n low during third byte -> all outputs 0 asynchronously, no done; after release, req[3] granted first-by-pointer order from 0.
